// File: rtl/iir_sched_pkg.sv
// Shared types and helpers for the IIR channel scheduler.
//   sched_state_e : scheduler FSM states
//   midscale()    : offset-binary zero level for a given sample width
//   ch_w()        : channel index width for a given channel count (at least 1)
package iir_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

  function automatic int unsigned midscale(int unsigned bitsize);
    return 32'd1 << (bitsize - 32'd1);
  endfunction

  function automatic int unsigned ch_w(int unsigned num_ch);
    return (num_ch < 32'd2) ? 32'd1 : 32'($clog2(num_ch));
  endfunction

endpackage

// File: rtl/iir_channel_scheduler_if.sv
// Bundle of every non-clock/reset signal of the IIR channel scheduler.
//   master : scheduler side (drives core start/select/data, result and status outputs)
//   slave  : environment side (ADC front-end, IIR core, downstream consumer)
// Signals:
//   EN, SMP_STRB, SMP_DATA, ERR_CLR          - front-end / control inputs
//   IIR_START, IIR_CH_SEL, IIR_DIN           - request to the shared core
//   IIR_DOUT, IIR_VALID                      - response from the core
//   DATA_OUT, CH_OUT, DATA_VALID             - tagged filtered result
//   OVERRUN, TIMEOUT_ERR, BUSY               - status
interface iir_channel_scheduler_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned BITSIZE = 16
);
  localparam int unsigned CH_W = iir_sched_pkg::ch_w(NUM_CH);

  logic                      EN;
  logic [NUM_CH-1:0]         SMP_STRB;
  logic [NUM_CH*BITSIZE-1:0] SMP_DATA;
  logic                      IIR_START;
  logic [CH_W-1:0]           IIR_CH_SEL;
  logic [BITSIZE-1:0]        IIR_DIN;
  logic [BITSIZE-1:0]        IIR_DOUT;
  logic                      IIR_VALID;
  logic [BITSIZE-1:0]        DATA_OUT;
  logic [CH_W-1:0]           CH_OUT;
  logic                      DATA_VALID;
  logic [NUM_CH-1:0]         OVERRUN;
  logic                      TIMEOUT_ERR;
  logic                      ERR_CLR;
  logic                      BUSY;

  modport master (
    input  EN, SMP_STRB, SMP_DATA, IIR_DOUT, IIR_VALID, ERR_CLR,
    output IIR_START, IIR_CH_SEL, IIR_DIN, DATA_OUT, CH_OUT, DATA_VALID,
           OVERRUN, TIMEOUT_ERR, BUSY
  );

  modport slave (
    output EN, SMP_STRB, SMP_DATA, IIR_DOUT, IIR_VALID, ERR_CLR,
    input  IIR_START, IIR_CH_SEL, IIR_DIN, DATA_OUT, CH_OUT, DATA_VALID,
           OVERRUN, TIMEOUT_ERR, BUSY
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req_i starting at ptr_i+1 (wrapping) and grants the first set bit.
//   req_i   : request vector
//   ptr_i   : index of the last granted requester
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted requester
//   valid_o : any request present
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  assign valid_o = |req_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    // i runs 1..NumReq so the last granted requester is examined last.
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/iir_channel_scheduler.sv
// Time-multiplexes one shared IIR core (per-channel state banks via CH_SEL) across
// NUM_CH ADC channels. Strobed samples are buffered per channel, arbitrated
// round-robin, issued to the core with a one-cycle START, and the core result is
// forwarded tagged with its channel. Flags sticky overrun and core timeout.
// Ports:
//   CLK  : system clock
//   nRST : asynchronous active-low reset
//   bus  : iir_channel_scheduler_if.master (control, core request/response, result, status)
module iir_channel_scheduler
  import iir_sched_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                    CLK,
  input logic                    nRST,
  iir_channel_scheduler_if.master bus
);

  localparam int unsigned        CH_W     = ch_w(NUM_CH);
  localparam int unsigned        CNT_W    = $clog2(TIMEOUT);
  localparam logic [BITSIZE-1:0] MIDSCALE = BITSIZE'(midscale(BITSIZE));

  sched_state_e       state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [NUM_CH-1:0]  pend_q, pend_d;
  logic [NUM_CH-1:0]  ovr_q, ovr_d;
  logic [BITSIZE-1:0] smp_buf_q [NUM_CH];
  logic [BITSIZE-1:0] smp_buf_d [NUM_CH];
  logic [BITSIZE-1:0] din_q, din_d;
  logic [BITSIZE-1:0] dout_q, dout_d;
  logic [CH_W-1:0]    ch_out_q, ch_out_d;
  logic               tmo_q, tmo_d;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_CH-1:0]  gnt;
  logic [CH_W-1:0]    gnt_idx;
  logic               gnt_valid;
  logic               valid_rise;

  rr_arbiter #(
    .NumReq (NUM_CH),
    .IdxW   (CH_W)
  ) u_arb (
    .req_i   (pend_q),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign valid_rise = bus.IIR_VALID & ~valid_q;

  // Sample capture, pending bits and overrun detection.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = bus.ERR_CLR ? '0 : ovr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      smp_buf_d[k] = smp_buf_q[k];
      if (bus.SMP_STRB[k]) begin
        smp_buf_d[k] = bus.SMP_DATA[k*BITSIZE +: BITSIZE];
        pend_d[k]    = 1'b1;
        // A strobe landing on the consuming ISSUE cycle re-arms pend; not an overrun.
        if (pend_q[k] && !(state_q == StIssue && ch_q == CH_W'(k))) begin
          ovr_d[k] = 1'b1;
        end
      end else if (state_q == StIssue && ch_q == CH_W'(k)) begin
        pend_d[k] = 1'b0;
      end
    end
  end

  // Job FSM.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    ptr_d    = ptr_q;
    din_d    = din_q;
    dout_d   = dout_q;
    ch_out_d = ch_out_q;
    cnt_d    = cnt_q;
    tmo_d    = bus.ERR_CLR ? 1'b0 : tmo_q;
    case (state_q)
      StIdle: begin
        if (bus.EN && gnt_valid) begin
          ch_d  = gnt_idx;
          ptr_d = gnt_idx;
          for (int k = 0; k < NUM_CH; k++) begin
            if (gnt[k]) din_d = smp_buf_q[k];
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (valid_rise) begin
          dout_d   = bus.IIR_DOUT;
          ch_out_d = ch_q;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Give up once the counter reaches TIMEOUT-1; the late result is dropped.
          if (cnt_d == CNT_W'(TIMEOUT - 1)) begin
            tmo_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      ptr_q    <= CH_W'(NUM_CH - 1);
      pend_q   <= '0;
      ovr_q    <= '0;
      din_q    <= MIDSCALE;
      dout_q   <= MIDSCALE;
      ch_out_q <= '0;
      tmo_q    <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        smp_buf_q[k] <= MIDSCALE;
      end
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      ch_out_q <= ch_out_d;
      tmo_q    <= tmo_d;
      valid_q  <= bus.IIR_VALID;
      cnt_q    <= cnt_d;
      for (int k = 0; k < NUM_CH; k++) begin
        smp_buf_q[k] <= smp_buf_d[k];
      end
    end
  end

  assign bus.IIR_START   = (state_q == StIssue);
  assign bus.IIR_CH_SEL  = ch_q;
  assign bus.IIR_DIN     = din_q;
  assign bus.DATA_OUT    = dout_q;
  assign bus.CH_OUT      = ch_out_q;
  assign bus.DATA_VALID  = (state_q == StDone);
  assign bus.OVERRUN     = ovr_q;
  assign bus.TIMEOUT_ERR = tmo_q;
  assign bus.BUSY        = (state_q != StIdle);

endmodule
